// File: rtl/spm_pkg.sv
// rtl/spm_pkg.sv - shared constants and FSM state encodings for the scratchpad AXI responder
//
// Purpose: AXI response codes, beat size, and write/read FSM state
//          encodings shared by spm_axi_responder and spm_bram.
// Ports:   none (package).
package spm_pkg;

  localparam int BEAT_BYTES = 16;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef logic [1:0] w_state_t;
  localparam w_state_t W_IDLE = 2'd0;
  localparam w_state_t W_DATA = 2'd1;
  localparam w_state_t W_RESP = 2'd2;

  typedef logic [1:0] r_state_t;
  localparam r_state_t R_IDLE  = 2'd0;
  localparam r_state_t R_FETCH = 2'd1;
  localparam r_state_t R_DATA  = 2'd2;

endpackage

// File: rtl/spm_bram.sv
// rtl/spm_bram.sv - simple dual-port scratchpad RAM, byte-enabled write, registered read
//
// Purpose: DEPTH x 128-bit storage. The write port updates the bytes selected by
//          wbe_i; the read port registers mem[raddr_i] when re_i is high and holds
//          the value otherwise. Same-address read and write in one cycle returns
//          the old contents (read-first). Contents are never reset.
// Ports:   clk_i               clock
//          we_i/waddr_i/wbe_i/wdata_i   write port
//          re_i/raddr_i/rdata_o         read port (one-cycle latency)
module spm_bram
  import spm_pkg::*;
#(
  parameter int DEPTH  = 131072,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                      clk_i,
  input  logic                      we_i,
  input  logic [ADDR_W-1:0]         waddr_i,
  input  logic [BEAT_BYTES-1:0]     wbe_i,
  input  logic [BEAT_BYTES*8-1:0]   wdata_i,
  input  logic                      re_i,
  input  logic [ADDR_W-1:0]         raddr_i,
  output logic [BEAT_BYTES*8-1:0]   rdata_o
);

  logic [BEAT_BYTES*8-1:0] mem_q [DEPTH];
  logic [BEAT_BYTES*8-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < BEAT_BYTES; i++) begin
        if (wbe_i[i]) begin
          mem_q[waddr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
        end
      end
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/spm_axi_responder.sv
// rtl/spm_axi_responder.sv - AXI4 INCR-burst slave in front of a 128-bit scratchpad
//
// Purpose: independent write (W_IDLE->W_DATA->W_RESP) and read
//          (R_IDLE->R_FETCH->R_DATA) state machines sharing one spm_bram.
//          Word index = (addr - BASE)[log2(SIZE)-1:4], incremented per beat,
//          wrapping at the end of the scratchpad.
// Build option: SPM_ADDR_CHECK_EN - bursts starting outside
//          [BASE, BASE+SIZE) write nothing and answer DECERR (reads return 0).
//          Without it the upper address bits are ignored (aliasing).
// Ports:   s00_axi_aclk / s00_axi_areset (sync, active-high)
//          AW: awid/awaddr/awlen/awvalid -> awready
//          W : wdata/wstrb/wlast/wvalid  -> wready
//          B : bid/bresp/bvalid          <- bready
//          AR: arid/araddr/arlen/arvalid -> arready
//          R : rid/rdata/rresp/rlast/rvalid <- rready
module spm_axi_responder
  import spm_pkg::*;
#(
  parameter int SPM_SIZE_IN_BYTE     = 2*1024*1024,
  parameter int C_S00_AXI_ID_WIDTH   = 16,
  parameter int C_S00_AXI_ADDR_WIDTH = 40,
  parameter int C_S00_AXI_DATA_WIDTH = 128,
  parameter logic [C_S00_AXI_ADDR_WIDTH-1:0] C_S00_AXI_BASE_ADDR = 40'h0
) (
  input  logic                              s00_axi_aclk,
  input  logic                              s00_axi_areset,
  input  logic [C_S00_AXI_ID_WIDTH-1:0]     s00_axi_awid,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [7:0]                        s00_axi_awlen,
  input  logic                              s00_axi_awvalid,
  output logic                              s00_axi_awready,
  input  logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S00_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                              s00_axi_wlast,
  input  logic                              s00_axi_wvalid,
  output logic                              s00_axi_wready,
  output logic [C_S00_AXI_ID_WIDTH-1:0]     s00_axi_bid,
  output logic [1:0]                        s00_axi_bresp,
  output logic                              s00_axi_bvalid,
  input  logic                              s00_axi_bready,
  input  logic [C_S00_AXI_ID_WIDTH-1:0]     s00_axi_arid,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [7:0]                        s00_axi_arlen,
  input  logic                              s00_axi_arvalid,
  output logic                              s00_axi_arready,
  output logic [C_S00_AXI_ID_WIDTH-1:0]     s00_axi_rid,
  output logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                        s00_axi_rresp,
  output logic                              s00_axi_rlast,
  output logic                              s00_axi_rvalid,
  input  logic                              s00_axi_rready
);

  localparam int AW       = C_S00_AXI_ADDR_WIDTH;
  localparam int IW       = C_S00_AXI_ID_WIDTH;
  localparam int ADDR_LSB = $clog2(SPM_SIZE_IN_BYTE);
  localparam int IDX_W    = ADDR_LSB - $clog2(BEAT_BYTES);
  localparam int DEPTH    = SPM_SIZE_IN_BYTE / BEAT_BYTES;

  // Offsets from the scratchpad base; with an aligned base the window test
  // reduces to "upper offset bits are zero".
  logic [AW-1:0] aw_off, ar_off;
  logic          aw_dec, ar_dec;
  assign aw_off = s00_axi_awaddr - C_S00_AXI_BASE_ADDR;
  assign ar_off = s00_axi_araddr - C_S00_AXI_BASE_ADDR;

`ifdef SPM_ADDR_CHECK_EN
  assign aw_dec = (aw_off[AW-1:ADDR_LSB] != '0);
  assign ar_dec = (ar_off[AW-1:ADDR_LSB] != '0);
  logic unused_addr_bits;
  assign unused_addr_bits = ^{aw_off[3:0], ar_off[3:0]};
`else
  assign aw_dec = 1'b0;
  assign ar_dec = 1'b0;
  logic unused_addr_bits;
  assign unused_addr_bits = ^{aw_off[AW-1:ADDR_LSB], aw_off[3:0],
                              ar_off[AW-1:ADDR_LSB], ar_off[3:0]};
`endif

  // ---------------- write side ----------------
  w_state_t         w_state_q, w_state_d;
  logic [IW-1:0]    w_id_q, w_id_d;
  logic [IDX_W-1:0] w_idx_q, w_idx_d;
  logic [7:0]       w_len_q, w_len_d, w_beat_q, w_beat_d;
  logic             w_slverr_q, w_slverr_d, w_dec_q, w_dec_d;
  logic             aw_hs, w_hs;

  assign s00_axi_awready = (w_state_q == W_IDLE) && !s00_axi_areset;
  assign s00_axi_wready  = (w_state_q == W_DATA) && !s00_axi_areset;
  assign s00_axi_bvalid  = (w_state_q == W_RESP) && !s00_axi_areset;
  assign s00_axi_bid     = w_id_q;
  assign s00_axi_bresp   = w_dec_q ? RESP_DECERR : (w_slverr_q ? RESP_SLVERR : RESP_OKAY);
  assign aw_hs = s00_axi_awvalid && s00_axi_awready;
  assign w_hs  = s00_axi_wvalid && s00_axi_wready;

  always_comb begin
    w_state_d  = w_state_q;
    w_id_d     = w_id_q;
    w_idx_d    = w_idx_q;
    w_len_d    = w_len_q;
    w_beat_d   = w_beat_q;
    w_slverr_d = w_slverr_q;
    w_dec_d    = w_dec_q;
    case (w_state_q)
      W_IDLE: if (aw_hs) begin
        w_id_d     = s00_axi_awid;
        w_idx_d    = aw_off[ADDR_LSB-1:4];
        w_len_d    = s00_axi_awlen;
        w_beat_d   = '0;
        w_slverr_d = 1'b0;
        w_dec_d    = aw_dec;
        w_state_d  = W_DATA;
      end
      W_DATA: if (w_hs) begin
        w_idx_d  = w_idx_q + 1'b1;
        w_beat_d = w_beat_q + 1'b1;
        // wlast is only checked; the beat count alone closes the burst.
        if (s00_axi_wlast != (w_beat_q == w_len_q)) w_slverr_d = 1'b1;
        if (w_beat_q == w_len_q) w_state_d = W_RESP;
      end
      W_RESP: if (s00_axi_bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  // ---------------- read side ----------------
  r_state_t         r_state_q, r_state_d;
  logic [IW-1:0]    r_id_q, r_id_d;
  logic [IDX_W-1:0] r_idx_q, r_idx_d;
  logic [7:0]       r_len_q, r_len_d, r_beat_q, r_beat_d;
  logic             r_dec_q, r_dec_d;
  logic             ar_hs;
  logic [C_S00_AXI_DATA_WIDTH-1:0] ram_rdata;

  assign s00_axi_arready = (r_state_q == R_IDLE) && !s00_axi_areset;
  assign s00_axi_rvalid  = (r_state_q == R_DATA) && !s00_axi_areset;
  assign s00_axi_rlast   = s00_axi_rvalid && (r_beat_q == r_len_q);
  assign s00_axi_rid     = r_id_q;
  assign s00_axi_rresp   = r_dec_q ? RESP_DECERR : RESP_OKAY;
  // RAM output register only reloads in R_FETCH, so rdata holds during stalls.
  assign s00_axi_rdata   = (s00_axi_rvalid && !r_dec_q) ? ram_rdata : '0;
  assign ar_hs = s00_axi_arvalid && s00_axi_arready;

  always_comb begin
    r_state_d = r_state_q;
    r_id_d    = r_id_q;
    r_idx_d   = r_idx_q;
    r_len_d   = r_len_q;
    r_beat_d  = r_beat_q;
    r_dec_d   = r_dec_q;
    case (r_state_q)
      R_IDLE: if (ar_hs) begin
        r_id_d    = s00_axi_arid;
        r_idx_d   = ar_off[ADDR_LSB-1:4];
        r_len_d   = s00_axi_arlen;
        r_beat_d  = '0;
        r_dec_d   = ar_dec;
        r_state_d = R_FETCH;
      end
      R_FETCH: r_state_d = R_DATA;
      R_DATA: if (s00_axi_rready) begin
        if (r_beat_q == r_len_q) begin
          r_state_d = R_IDLE;
        end else begin
          r_beat_d  = r_beat_q + 1'b1;
          r_idx_d   = r_idx_q + 1'b1;
          r_state_d = R_FETCH;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      w_state_q <= W_IDLE;  w_id_q <= '0;  w_idx_q <= '0;  w_len_q <= '0;
      w_beat_q  <= '0;      w_slverr_q <= 1'b0;  w_dec_q <= 1'b0;
      r_state_q <= R_IDLE;  r_id_q <= '0;  r_idx_q <= '0;  r_len_q <= '0;
      r_beat_q  <= '0;      r_dec_q <= 1'b0;
    end else begin
      w_state_q <= w_state_d;  w_id_q <= w_id_d;  w_idx_q <= w_idx_d;  w_len_q <= w_len_d;
      w_beat_q  <= w_beat_d;   w_slverr_q <= w_slverr_d;  w_dec_q <= w_dec_d;
      r_state_q <= r_state_d;  r_id_q <= r_id_d;  r_idx_q <= r_idx_d;  r_len_q <= r_len_d;
      r_beat_q  <= r_beat_d;   r_dec_q <= r_dec_d;
    end
  end

  spm_bram #(
    .DEPTH (DEPTH),
    .ADDR_W(IDX_W)
  ) u_bram (
    .clk_i  (s00_axi_aclk),
    .we_i   (w_hs && !w_dec_q),
    .waddr_i(w_idx_q),
    .wbe_i  (s00_axi_wstrb),
    .wdata_i(s00_axi_wdata),
    .re_i   (r_state_q == R_FETCH),
    .raddr_i(r_idx_q),
    .rdata_o(ram_rdata)
  );

endmodule

// File: tb/tb_spm_axi_responder.sv
// tb/tb_spm_axi_responder.sv - scoreboard bench for spm_axi_responder
module tb_spm_axi_responder;

  localparam int SIZE  = 2*1024*1024;
  localparam int DEPTH = SIZE / 16;

  logic         clk = 1'b0;
  logic         areset;
  logic [15:0]  awid, arid, bid, rid;
  logic [39:0]  awaddr, araddr;
  logic [7:0]   awlen, arlen;
  logic         awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic         arvalid, arready, rlast, rvalid, rready;
  logic [127:0] wdata, rdata;
  logic [15:0]  wstrb;
  logic [1:0]   bresp, rresp;

  always #5 clk = ~clk;

  spm_axi_responder dut (
    .s00_axi_aclk(clk), .s00_axi_areset(areset),
    .s00_axi_awid(awid), .s00_axi_awaddr(awaddr), .s00_axi_awlen(awlen),
    .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
    .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wlast(wlast),
    .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
    .s00_axi_bid(bid), .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
    .s00_axi_arid(arid), .s00_axi_araddr(araddr), .s00_axi_arlen(arlen),
    .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rid(rid), .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rlast(rlast),
    .s00_axi_rvalid(rvalid), .s00_axi_rready(rready)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct { logic [127:0] data; logic last; logic [1:0] resp; logic [15:0] id; } rbeat_t;
  typedef struct { logic [15:0] id; logic [1:0] resp; } bexp_t;
  rbeat_t rq[$];
  bexp_t  bq[$];

  logic [127:0] model [int];
  logic [127:0] wd [16];
  logic [15:0]  ws [16];

  function automatic logic [127:0] model_rd(input int idx);
    return model.exists(idx) ? model[idx] : 128'h0;
  endfunction

  function automatic int word_of(input logic [39:0] addr);
    return int'((addr >> 4) & 40'(DEPTH - 1));
  endfunction

  task automatic write_burst(input logic [39:0] addr, input int len, input logic [15:0] id,
                             input int wlast_at, input bit dec);
    int idx, n;
    bexp_t e;
    logic [127:0] cur;
    idx = word_of(addr);
    @(posedge clk); #1;
    awaddr = addr; awlen = 8'(len); awid = id; awvalid = 1'b1;
    n = 0; @(negedge clk);
    while (!awready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) check_eq("aw_timeout", 1, 0);
    @(posedge clk); #1 awvalid = 1'b0;
    for (int b = 0; b <= len; b++) begin
      wdata = wd[b]; wstrb = ws[b]; wlast = (b == wlast_at); wvalid = 1'b1;
      n = 0; @(negedge clk);
      while (!wready && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) check_eq("w_timeout", 1, 0);
      @(posedge clk); #1;
      if (!dec) begin
        cur = model_rd(idx);
        for (int k = 0; k < 16; k++) if (ws[b][k]) cur[k*8 +: 8] = wd[b][k*8 +: 8];
        model[idx] = cur;
      end
      idx = (idx + 1) % DEPTH;
    end
    wvalid = 1'b0; wlast = 1'b0;
    e.id = id;
    e.resp = dec ? 2'b11 : ((wlast_at != len) ? 2'b10 : 2'b00);
    bq.push_back(e);
    bready = 1'b1;
    n = 0; @(negedge clk);
    while (!bvalid && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      check_eq("b_timeout", 1, 0);
      bq.delete();
    end else begin
      e = bq.pop_front();
      check_eq("bid", bid, e.id);
      check_eq("bresp", bresp, e.resp);
    end
    @(posedge clk); #1 bready = 1'b0;
  endtask

  task automatic read_burst(input logic [39:0] addr, input int len, input logic [15:0] id,
                            input bit dec, input int stall);
    int idx, n, got;
    rbeat_t e;
    logic [127:0] first;
    idx = word_of(addr);
    for (int b = 0; b <= len; b++) begin
      e.data = dec ? 128'h0 : model_rd(idx);
      e.last = (b == len);
      e.resp = dec ? 2'b11 : 2'b00;
      e.id   = id;
      rq.push_back(e);
      idx = (idx + 1) % DEPTH;
    end
    @(posedge clk); #1;
    araddr = addr; arlen = 8'(len); arid = id; arvalid = 1'b1; rready = (stall == 0);
    n = 0; @(negedge clk);
    while (!arready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) check_eq("ar_timeout", 1, 0);
    @(posedge clk); #1 arvalid = 1'b0;
    n = 1; @(negedge clk);
    while (!rvalid && n < 50) begin @(negedge clk); n++; end
    check_eq("r_latency", n, 2);
    first = rdata;
    for (int s = 0; s < stall; s++) begin
      check_eq("stall_rvalid", rvalid, 1);
      check_eq("stall_rdata", rdata, first);
      @(posedge clk); #1;
      if (s == stall - 1) rready = 1'b1;
      @(negedge clk);
    end
    got = 0; n = 0;
    while (got <= len && n < 200) begin
      if (rvalid && rready) begin
        e = rq.pop_front();
        check_eq("rdata", rdata, e.data);
        check_eq("rlast", rlast, e.last);
        check_eq("rresp", rresp, e.resp);
        check_eq("rid", rid, e.id);
        got++;
      end
      if (got <= len) begin @(negedge clk); n++; end
    end
    if (got <= len) begin
      check_eq("r_timeout", got, len + 1);
      rq.delete();
    end
    @(posedge clk); #1 rready = 1'b0;
  endtask

  task automatic fill_full();
    for (int b = 0; b < 16; b++) ws[b] = 16'hFFFF;
  endtask

  initial begin
    int n;
    logic [39:0] a;
    int len;
    areset = 1'b1; awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    awid = 0; awaddr = 0; awlen = 0; wdata = 0; wstrb = 0; wlast = 0;
    arid = 0; araddr = 0; arlen = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_awready", awready, 0);
    check_eq("rst_wready", wready, 0);
    check_eq("rst_arready", arready, 0);
    check_eq("rst_bvalid", bvalid, 0);
    check_eq("rst_rvalid", rvalid, 0);
    check_eq("rst_rlast", rlast, 0);
    check_eq("rst_bresp_bid", {bresp, bid}, 0);
    check_eq("rst_rresp_rid", {rresp, rid}, 0);
    check_eq("rst_rdata", rdata, 0);
    @(posedge clk); #1 areset = 1'b0;
    @(negedge clk);
    check_eq("rel_awready", awready, 1);
    check_eq("rel_arready", arready, 1);

    // 4-beat burst write then read back
    fill_full();
    for (int b = 0; b < 4; b++) wd[b] = {4{32'hA5A5_0000 + 32'(b)}};
    write_burst(40'h100, 3, 16'd5, 3, 0);
    read_burst(40'h100, 3, 16'd9, 0, 0);

    // partial strobe over zero word
    wd[0] = '0;
    write_burst(40'h0, 0, 16'd1, 0, 0);
    wd[0] = {128{1'b1}}; ws[0] = 16'h000F;
    write_burst(40'h0, 0, 16'd1, 0, 0);
    check_eq("strb_model", model_rd(0), 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF);
    read_burst(40'h0, 0, 16'd2, 0, 0);

    // early wlast -> SLVERR, both beats still written; stalled read
    fill_full();
    wd[0] = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    wd[1] = 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000;
    write_burst(40'h200, 1, 16'd6, 0, 0);
    read_burst(40'h200, 1, 16'd7, 0, 5);

    // wrap from last word to word 0
    wd[0] = 128'hDEAD_BEEF_0000_0000_0000_0000_CAFE_F00D;
    wd[1] = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    write_burst(40'(SIZE - 16), 1, 16'd8, 1, 0);
    read_burst(40'h0, 0, 16'd3, 0, 0);
    read_burst(40'(SIZE - 16), 1, 16'd4, 0, 0);

`ifdef SPM_ADDR_CHECK_EN
    read_burst(40'(SIZE), 0, 16'd10, 1, 0);
    wd[0] = {4{32'h5555_AAAA}};
    write_burst(40'(SIZE), 0, 16'd11, 0, 1);
    read_burst(40'h0, 0, 16'd12, 0, 0);
`else
    wd[0] = {4{32'h1234_5678}};
    write_burst(40'(SIZE) + 40'h300, 0, 16'd11, 0, 0);
    read_burst(40'h300, 0, 16'd12, 0, 0);
`endif

    // randomized bursts: full write, partial overwrite, readback
    for (int it = 0; it < 3; it++) begin
      a = 40'($urandom_range(256, 4000)) << 4;
      len = $urandom_range(0, 5);
      fill_full();
      for (int b = 0; b < 16; b++) wd[b] = {$urandom, $urandom, $urandom, $urandom};
      write_burst(a, len, 16'(it), len, 0);
      for (int b = 0; b < 16; b++) begin
        wd[b] = {$urandom, $urandom, $urandom, $urandom};
        ws[b] = 16'($urandom);
      end
      write_burst(a, len, 16'(it + 100), len, 0);
      read_burst(a, len, 16'(it + 200), 0, 0);
    end

    // reset during beat 2 of an 8-beat read
    fill_full();
    for (int b = 0; b < 8; b++) wd[b] = {4{32'hC0DE_0000 + 32'(b)}};
    write_burst(40'h400, 7, 16'd20, 7, 0);
    @(posedge clk); #1;
    araddr = 40'h400; arlen = 8'd7; arid = 16'd21; arvalid = 1'b1; rready = 1'b1;
    n = 0; @(negedge clk);
    while (!arready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1 arvalid = 1'b0;
    n = 0; @(negedge clk);
    while (!rvalid && n < 50) begin @(negedge clk); n++; end
    check_eq("rst_beat1", rdata, model_rd(word_of(40'h400)));
    @(posedge clk); #1 areset = 1'b1;
    @(negedge clk);
    check_eq("midrst_rvalid", rvalid, 0);
    check_eq("midrst_arready", arready, 0);
    @(posedge clk); #1;
    @(posedge clk); #1 areset = 1'b0;
    @(negedge clk);
    check_eq("post_rst_arready", arready, 1);
    check_eq("post_rst_rvalid", rvalid, 0);
    rready = 1'b0;
    read_burst(40'h400, 7, 16'd22, 0, 0);

    check_eq("rq_empty", rq.size(), 0);
    check_eq("bq_empty", bq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spm_axi_responder.md
SPM_AXI_RESPONDER -- requirements
Module: spm_axi_responder

Interface
REQ-001 SPM_SIZE_IN_BYTE, 2*1024*1024, scratchpad capacity; power of two, at least 16.
REQ-002 C_S00_AXI_ID_WIDTH, 16, AXI ID width.
REQ-003 C_S00_AXI_ADDR_WIDTH, 40, AXI address width.
REQ-004 C_S00_AXI_DATA_WIDTH, 128, data width; fixed at 128.
REQ-005 C_S00_AXI_BASE_ADDR, 40'h0, SPM base address; aligned to SPM_SIZE_IN_BYTE.
REQ-006 s00_axi_aclk  in  1  single clock; all logic on rising edge.
REQ-007 s00_axi_areset  in  1  synchronous, active-high reset.
REQ-008 s00_axi_awid/awaddr/awlen/awvalid  in  ID/ADDR/8/1; s00_axi_awready  out  1  write-address channel.
REQ-009 s00_axi_wdata/wstrb/wlast/wvalid  in  128/16/1/1; s00_axi_wready  out  1  write-data channel.
REQ-010 s00_axi_bid/bresp/bvalid  out  ID/2/1; s00_axi_bready  in  1  write-response channel.
REQ-011 s00_axi_arid/araddr/arlen/arvalid  in  ID/ADDR/8/1; s00_axi_arready  out  1  read-address channel.
REQ-012 s00_axi_rid/rdata/rresp/rlast/rvalid  out  ID/128/2/1/1; s00_axi_rready  in  1  read-data channel.

Function
REQ-013 Bursts SHALL be INCR with 16-byte beats; awsize/arsize/burst are not ports; addr[3:0] ignored.
REQ-014 Word index SHALL be (addr - BASE)[log2(SPM_SIZE_IN_BYTE)-1:4]; within a burst it increments by 1 per beat and wraps modulo SPM_SIZE_IN_BYTE/16.
REQ-015 Write FSM W_IDLE->W_DATA->W_RESP->W_IDLE: awready=1 only in W_IDLE; AW handshake latches id, index, len, clears beat counter.
REQ-016 In W_DATA, wready=1; each W handshake writes bytes selected by wstrb in the same cycle; after beat awlen+1 the FSM goes to W_RESP.
REQ-017 If wlast differs from (beat==awlen) on any beat, bresp SHALL be SLVERR (2'b10); beat count alone ends the burst.
REQ-018 In W_RESP, bvalid=1 with latched bid; bvalid/bid/bresp held stable until bready; then W_IDLE.
REQ-019 Read FSM R_IDLE->R_FETCH->R_DATA: arready=1 only in R_IDLE; R_FETCH issues RAM read (1-cycle latency); R_DATA drives rvalid=1, rdata registered.
REQ-020 rdata/rresp/rlast/rid SHALL be stable while rvalid&&!rready; on handshake, return to R_FETCH for the next beat, or R_IDLE after beat arlen (rlast=1).
REQ-021 First rvalid SHALL assert exactly 2 cycles after AR handshake; peak read throughput is one beat per 2 cycles.
REQ-022 Read and write FSMs are independent and may run concurrently; same-word same-cycle read/write SHALL return old data (read-first).

Reset
REQ-023 While s00_axi_areset=1: both FSMs idle, counters 0, awready/wready/arready/bvalid/rvalid/rlast=0, bresp/rresp/bid/rid/rdata=0; ready outputs assert the first cycle after release.
REQ-024 Reset mid-burst SHALL abandon the burst without a response; RAM contents SHALL NOT be reset.

Configuration
REQ-025 SPM_ADDR_CHECK_EN defined: a burst whose start address lies outside [BASE, BASE+SPM_SIZE_IN_BYTE) SHALL write nothing (wready still 1, all beats consumed), return bresp=DECERR (2'b11), read rdata=0 with rresp=DECERR on every beat; DECERR overrides SLVERR.
REQ-026 SPM_ADDR_CHECK_EN undefined: upper address bits ignored (aliasing); resp always OKAY except SLVERR per REQ-017.

Structure
REQ-027 Package spm_pkg SHALL hold resp codes (OKAY/SLVERR/DECERR), W/R FSM state typedefs, beat-bytes constant 16.
REQ-028 Sub-module spm_bram: dual-port (write port, read port), 16 byte enables, registered read, depth SPM_SIZE_IN_BYTE/16.

Verification
REQ-029 AW addr=0x100 len=3 id=5, 4 beats full strb -> bid=5 bresp=00; AR 0x100 len=3 -> same 4 words, rlast on beat 4, first rvalid 2 cycles after AR.
REQ-030 Write 0x0 wstrb=0x000F data=all-ones over prior 0 -> read returns 0x...0000_FFFFFFFF.
REQ-031 AW len=1 with wlast on beat 1 -> bresp=10, both beats written; rready held 0 for 5 cycles -> rdata stable, rvalid stays 1.
REQ-032 Write burst at last word (BASE+SIZE-16) len=1 -> second beat lands at word 0 (wrap).
REQ-033 SPM_ADDR_CHECK_EN: AR at BASE+SIZE len=0 -> rdata=0 rresp=11; AW same -> bresp=11, memory unchanged.
REQ-034 Reset asserted during beat 2 of len=7 read -> rvalid=0 next cycle, arready=1 cycle after release, new burst correct.
